// File: rtl/ppu_bg_fetch_pkg.sv
// ppu_bg_fetch_pkg: shared phase encoding and VRAM base addresses for the background fetcher
package ppu_bg_fetch_pkg;
  typedef enum logic [2:0] {
    PH_NT_ADDR, PH_NT_DATA, PH_AT_ADDR, PH_AT_DATA,
    PH_PT_LO_ADDR, PH_PT_LO_DATA, PH_PT_HI_ADDR, PH_PT_HI_DATA
  } phase_e;
  localparam logic [13:0] NT_BASE = 14'h2000;
  localparam logic [13:0] AT_BASE = 14'h23C0;
  localparam logic [13:0] PT_HI_OFFSET = 14'd8;
endpackage

// File: rtl/ppu_bg_fetch_if.sv
// ppu_bg_fetch_if: VRAM read bus between the background fetcher (master) and VRAM (slave)
// vram_addr/vram_rd: fetch address and read strobe; vram_data: read data, valid the cycle after vram_rd
interface ppu_bg_fetch_if #(parameter int ADDR_WIDTH = 14);
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic                  vram_rd;
  logic [7:0]            vram_data;
  modport master (output vram_addr, vram_rd, input vram_data);
  modport slave (input vram_addr, vram_rd, output vram_data);
endinterface

// File: rtl/ppu_bg_attr_sel.sv
// ppu_bg_attr_sel: attribute-table address and 2-bit palette quadrant select from loopy v
// i_v: loopy v; i_at_byte: attribute byte; o_at_addr: attribute fetch address; o_pal: selected palette
module ppu_bg_attr_sel
  import ppu_bg_fetch_pkg::*;
(
  input  logic [14:0] i_v,
  input  logic [7:0]  i_at_byte,
  output logic [13:0] o_at_addr,
  output logic [1:0]  o_pal
);
  logic [7:0] w_shifted;
  logic       w_unused;
  assign w_unused = ^{i_v[14:12], i_v[5], i_v[0]};
  always_comb begin
    o_at_addr = AT_BASE | {2'b00, i_v[11:10], 4'b0000, i_v[9:7], i_v[4:2]};
    w_shifted = i_at_byte >> {i_v[6], i_v[1], 1'b0};
    o_pal = w_shifted[1:0];
  end
endmodule

// File: rtl/ppu_bg_fetch.sv
// ppu_bg_fetch: 8-dot NT/AT/PT-lo/PT-hi background tile fetch sequencer feeding the BG shift registers
// i_clk, i_reset_n (sync, active-low), i_enable, i_v (loopy v), i_bg_table; vram: VRAM read bus (master)
// o_pattern_lo/hi, o_attr_lo/hi: current tile; o_load/o_shift: shift-register strobes; o_inc_coarse_x
// PPU_BG_FETCH_DEBUG_EN adds o_debug_phase and o_debug_nt
module ppu_bg_fetch
  import ppu_bg_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_enable,
  input  logic [14:0]  i_v,
  input  logic         i_bg_table,
  ppu_bg_fetch_if.master vram,
  output logic [7:0]   o_pattern_lo,
  output logic [7:0]   o_pattern_hi,
  output logic [7:0]   o_attr_lo,
  output logic [7:0]   o_attr_hi,
  output logic         o_load,
  output logic         o_shift,
  output logic         o_inc_coarse_x
`ifdef PPU_BG_FETCH_DEBUG_EN
  ,
  output logic [2:0]   o_debug_phase,
  output logic [7:0]   o_debug_nt
`endif
);
  phase_e      r_phase, w_phase_nxt;
  logic [7:0]  r_nt, r_pt_lo;
  logic [1:0]  r_pal, w_pal;
  logic        r_load, w_act, w_rd;
  logic [13:0] w_at_addr, w_pt_addr, w_addr;
  ppu_bg_attr_sel u_attr_sel (
    .i_v       (i_v),
    .i_at_byte (vram.vram_data),
    .o_at_addr (w_at_addr),
    .o_pal     (w_pal)
  );
  assign w_pt_addr = {1'b0, i_bg_table, r_nt, 1'b0, i_v[14:12]};
  always_ff @(posedge i_clk)
    r_phase <= !i_reset_n ? PH_NT_ADDR : w_phase_nxt;
  // Strobes are also gated by reset so the bus is idle while reset is held.
  always_comb begin
    w_act = i_enable & i_reset_n;
    w_phase_nxt = i_enable ? phase_e'(r_phase + 3'd1) : PH_NT_ADDR;
    w_rd = w_act & ~r_phase[0];
    w_addr = r_phase == PH_NT_ADDR ? NT_BASE | {2'b00, i_v[11:0]} :
             r_phase == PH_AT_ADDR ? w_at_addr :
             r_phase == PH_PT_LO_ADDR ? w_pt_addr : w_pt_addr | PT_HI_OFFSET;
    vram.vram_rd = w_rd;
    vram.vram_addr = w_rd ? ADDR_WIDTH'(w_addr) : '0;
    o_shift = w_act;
    o_load = r_load & w_act;
    o_inc_coarse_x = w_act & (r_phase == PH_PT_HI_DATA);
  end
  // Transfer at the end of phase 7 ignores i_enable: a tile whose last fetch completed is kept.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_nt <= '0;
      r_pt_lo <= '0;
      r_pal <= '0;
      r_load <= 1'b0;
      o_pattern_lo <= '0;
      o_pattern_hi <= '0;
      o_attr_lo <= '0;
      o_attr_hi <= '0;
    end else begin
      r_load <= i_enable & (r_phase == PH_PT_HI_DATA);
      if (i_enable && r_phase == PH_NT_DATA) r_nt <= vram.vram_data;
      if (i_enable && r_phase == PH_AT_DATA) r_pal <= w_pal;
      if (i_enable && r_phase == PH_PT_LO_DATA) r_pt_lo <= vram.vram_data;
      if (r_phase == PH_PT_HI_DATA) begin
        o_pattern_lo <= r_pt_lo;
        o_pattern_hi <= vram.vram_data;
        o_attr_lo <= {8{r_pal[0]}};
        o_attr_hi <= {8{r_pal[1]}};
      end
    end
  end
`ifdef PPU_BG_FETCH_DEBUG_EN
  assign o_debug_phase = r_phase;
  assign o_debug_nt = r_nt;
`endif
endmodule
